// File: rtl/tcam_pkg.sv
// Shared types and sizing for the TCAM lookup controller and its priority encoder.
package tcam_pkg;

    localparam int WORD_SIZE    = 8;
    localparam int ADDRESS_SIZE = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_SEARCH,
        ST_CAPTURE,
        ST_RESP,
        ST_CLEAR
    } state_e;

    typedef enum logic {
        GRANT_UPDATE,
        GRANT_SEARCH
    } grant_e;

    function automatic int entry_count(input int address_size);
        return 1 << address_size;
    endfunction

endpackage

// File: rtl/tcam_priority_encoder.sv
// Reduces a match vector to: any hit, lowest set index, and number of set bits.
module tcam_priority_encoder #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic [N-1:0] matched,
    output logic         hit,
    output logic [AW-1:0] address,
    output logic [AW:0]  count
);

    always_comb begin
        hit     = |matched;
        address = '0;
        count   = '0;
        // Walk downward so the last assignment is the lowest set index.
        for (int i = N - 1; i >= 0; i--) begin
            if (matched[i]) address = AW'(i);
        end
        for (int i = 0; i < N; i++) begin
            count = count + (AW + 1)'(matched[i]);
        end
    end

endmodule

// File: rtl/tcam_lookup_controller.sv
// Arbitrates update and search requests onto a ternary CAM, masks results with a
// per-entry valid bitmap and returns the lowest hit address plus match count.
module tcam_lookup_controller #(
    parameter int WORD_SIZE    = tcam_pkg::WORD_SIZE,
    parameter int ADDRESS_SIZE = tcam_pkg::ADDRESS_SIZE
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [ADDRESS_SIZE-1:0]      upd_address,
    input  logic [WORD_SIZE-1:0]         upd_word,
    input  logic                         upd_delete,
    input  logic                         srch_valid,
    output logic                         srch_ready,
    input  logic [WORD_SIZE-1:0]         srch_word,
    input  logic [WORD_SIZE-1:0]         srch_mask,
    input  logic                         clr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_hit,
    output logic [ADDRESS_SIZE-1:0]      rsp_address,
    output logic [ADDRESS_SIZE:0]        rsp_count,
    output logic                         busy,
    output logic [WORD_SIZE-1:0]         tcam_word,
    output logic [WORD_SIZE-1:0]         tcam_mask,
    output logic [ADDRESS_SIZE-1:0]      tcam_address,
    output logic                         tcam_write,
    output logic                         tcam_reset,
    input  logic [(1<<ADDRESS_SIZE)-1:0] tcam_matched,
    output tcam_pkg::state_e             state
);

    import tcam_pkg::*;

    localparam int N = entry_count(ADDRESS_SIZE);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; ready never depends on anything but IDLE state,
    // clr, last_grant and the other requester's valid.
    state_e                  state_next;
    grant_e                  last_grant;
    logic [N-1:0]            valid_map;
    logic [ADDRESS_SIZE-1:0] cap_address;
    logic [WORD_SIZE-1:0]    cap_word;
    logic [WORD_SIZE-1:0]    cap_mask;
    logic                    cap_delete;
    logic                    upd_fire;
    logic                    srch_fire;
    logic                    enc_hit;
    logic [ADDRESS_SIZE-1:0] enc_address;
    logic [ADDRESS_SIZE:0]   enc_count;

    always_comb begin
        state_next = state;
        upd_ready  = 1'b0;
        srch_ready = 1'b0;
        case (state)
            ST_INIT:    state_next = ST_IDLE;
            ST_IDLE: begin
                if (clr) begin
                    state_next = ST_CLEAR;
                end else begin
                    upd_ready  = !srch_valid || (last_grant == GRANT_SEARCH);
                    srch_ready = !upd_valid  || (last_grant == GRANT_UPDATE);
                    if (upd_valid && upd_ready)        state_next = ST_WRITE;
                    else if (srch_valid && srch_ready) state_next = ST_SEARCH;
                end
            end
            ST_WRITE:   state_next = ST_IDLE;
            ST_SEARCH:  state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_RESP;
            ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
            ST_CLEAR:   state_next = ST_IDLE;
            default:    state_next = ST_INIT;
        endcase
    end

    assign upd_fire  = upd_valid && upd_ready;
    assign srch_fire = srch_valid && srch_ready;

    tcam_priority_encoder #(.N(N), .AW(ADDRESS_SIZE)) u_encoder (
        .matched (tcam_matched & valid_map),
        .hit     (enc_hit),
        .address (enc_address),
        .count   (enc_count)
    );

    // The CAM reset pin is held high through our own reset so that the INIT
    // cycle that follows drives it as CLEAR would.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_INIT;
            last_grant  <= GRANT_SEARCH;
            valid_map   <= '0;
            cap_address <= '0;
            cap_word    <= '0;
            cap_mask    <= '0;
            cap_delete  <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_address <= '0;
            rsp_count   <= '0;
            tcam_write  <= 1'b0;
            tcam_reset  <= 1'b1;
        end else begin
            state      <= state_next;
            tcam_write <= (state_next == ST_WRITE);
            tcam_reset <= (state_next == ST_CLEAR);
            if (upd_fire) begin
                cap_address <= upd_address;
                cap_word    <= upd_delete ? '0 : upd_word;
                cap_mask    <= '0;
                cap_delete  <= upd_delete;
                last_grant  <= GRANT_UPDATE;
            end
            if (srch_fire) begin
                cap_word   <= srch_word;
                cap_mask   <= srch_mask;
                last_grant <= GRANT_SEARCH;
            end
            if (state == ST_WRITE) valid_map[cap_address] <= !cap_delete;
            if (state == ST_INIT || state == ST_CLEAR) valid_map <= '0;
            if (state == ST_CAPTURE) begin
                rsp_hit     <= enc_hit;
                rsp_address <= enc_address;
                rsp_count   <= enc_count;
            end
        end
    end

    assign rsp_valid    = (state == ST_RESP);
    assign busy         = (state != ST_IDLE);
    assign tcam_word    = cap_word;
    assign tcam_mask    = cap_mask;
    assign tcam_address = cap_address;

endmodule

// File: tb/tb_tcam_lookup_controller.sv
// Directed bench for tcam_lookup_controller with a behavioural ternary CAM model.
module tb_tcam_lookup_controller;

  import tcam_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [3:0]  upd_address = '0;
  logic [7:0]  upd_word = '0;
  logic        upd_delete = 1'b0;
  logic        srch_valid = 1'b0;
  logic        srch_ready;
  logic [7:0]  srch_word = '0;
  logic [7:0]  srch_mask = '0;
  logic        clr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit;
  logic [3:0]  rsp_address;
  logic [4:0]  rsp_count;
  logic        busy;
  logic [7:0]  tcam_word;
  logic [7:0]  tcam_mask;
  logic [3:0]  tcam_address;
  logic        tcam_write;
  logic        tcam_reset;
  logic [15:0] tcam_matched = '0;
  state_e      state;

  int checks = 0;
  int errors = 0;

  tcam_lookup_controller #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) dut (
    .clock(clock), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_address(upd_address),
    .upd_word(upd_word), .upd_delete(upd_delete),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_word(srch_word),
    .srch_mask(srch_mask), .clr(clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_address(rsp_address), .rsp_count(rsp_count), .busy(busy),
    .tcam_word(tcam_word), .tcam_mask(tcam_mask), .tcam_address(tcam_address),
    .tcam_write(tcam_write), .tcam_reset(tcam_reset), .tcam_matched(tcam_matched),
    .state(state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural CAM: stored words, per-search mask, matched latched every edge
  logic [7:0] cam_mem [16];
  always @(posedge clock) begin
    for (int i = 0; i < 16; i++)
      tcam_matched[i] <= (((cam_mem[i] ^ tcam_word) & ~tcam_mask) == 8'h00);
    if (tcam_reset) begin
      for (int i = 0; i < 16; i++) cam_mem[i] <= 8'h00;
    end else if (tcam_write) begin
      cam_mem[tcam_address] <= tcam_word;
    end
  end

  // driver tasks
  task automatic do_update(input logic [3:0] a, input logic [7:0] w, input logic del,
                           output logic wr, output logic [3:0] ad, output logic [7:0] wd,
                           output logic idle);
    int n;
    n = 0;
    @(posedge clock); #1;
    upd_address = a; upd_word = w; upd_delete = del; upd_valid = 1'b1;
    @(negedge clock);
    while (!upd_ready && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (!upd_ready) begin errors++; $display("FAIL upd_accept_timeout: upd_ready=%0b required 1", upd_ready); end
    @(posedge clock); #1;
    upd_valid = 1'b0;
    @(negedge clock);
    wr = tcam_write; ad = tcam_address; wd = tcam_word;
    @(negedge clock);
    idle = !busy;
  endtask

  task automatic do_search(input logic [7:0] w, input logic [7:0] m,
                           output logic hit, output logic [3:0] addr,
                           output logic [4:0] cnt, output int lat);
    int n;
    n = 0;
    @(posedge clock); #1;
    srch_word = w; srch_mask = m; srch_valid = 1'b1;
    @(negedge clock);
    while (!srch_ready && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (!srch_ready) begin errors++; $display("FAIL srch_accept_timeout: srch_ready=%0b required 1", srch_ready); end
    @(posedge clock); #1;
    srch_valid = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!rsp_valid && lat < 20);
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid); end
    hit = rsp_hit; addr = rsp_address; cnt = rsp_count;
  endtask

  // tests
  task automatic test_reset;
    int pulses, n;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (state !== ST_INIT) begin errors++; $display("FAIL reset_state: got %0d required %0d", state, ST_INIT); end
    checks++;
    if ({rsp_valid, upd_ready, srch_ready, tcam_write, busy} !== 5'b00001) begin
      errors++; $display("FAIL reset_outputs: got %b required 00001", {rsp_valid, upd_ready, srch_ready, tcam_write, busy});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    pulses = 0; n = 0;
    do begin @(negedge clock); if (tcam_reset) pulses++; n++; end while (busy && n < 10);
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL init_tcam_reset_cycles: got %0d required 1", pulses); end
    checks++;
    if (state !== ST_IDLE) begin errors++; $display("FAIL init_to_idle: got %0d required %0d", state, ST_IDLE); end
  endtask

  task automatic test_empty_search;
    logic h; logic [3:0] a; logic [4:0] c; int lat;
    do_search(8'h00, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b0, 4'd0, 5'd0}) begin errors++; $display("FAIL empty_search: got hit=%0b addr=%0d cnt=%0d required 0 0 0", h, a, c); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL search_latency: got %0d required 3", lat); end
  endtask

  task automatic test_insert_delete;
    logic wr, idle; logic [3:0] ad; logic [7:0] wd;
    logic h; logic [3:0] a; logic [4:0] c; int lat;
    do_update(4'd3, 8'hA5, 1'b0, wr, ad, wd, idle);
    checks++;
    if ({wr, ad, wd, idle} !== {1'b1, 4'd3, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL insert_write_pins: got wr=%0b addr=%0d word=%h idle=%0b required 1 3 a5 1", wr, ad, wd, idle);
    end
    do_update(4'd9, 8'hA5, 1'b0, wr, ad, wd, idle);
    do_search(8'hA5, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b1, 4'd3, 5'd2}) begin errors++; $display("FAIL search_two_hits: got hit=%0b addr=%0d cnt=%0d required 1 3 2", h, a, c); end
    do_update(4'd3, 8'hFF, 1'b1, wr, ad, wd, idle);
    checks++;
    if ({wr, ad, wd, idle} !== {1'b1, 4'd3, 8'h00, 1'b1}) begin
      errors++; $display("FAIL delete_write_pins: got wr=%0b addr=%0d word=%h idle=%0b required 1 3 00 1", wr, ad, wd, idle);
    end
    do_search(8'hA5, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b1, 4'd9, 5'd1}) begin errors++; $display("FAIL search_after_delete: got hit=%0b addr=%0d cnt=%0d required 1 9 1", h, a, c); end
  endtask

  task automatic test_ternary;
    logic wr, idle; logic [3:0] ad; logic [7:0] wd;
    logic h; logic [3:0] a; logic [4:0] c; int lat;
    do_update(4'd1, 8'hF0, 1'b0, wr, ad, wd, idle);
    do_update(4'd2, 8'hF3, 1'b0, wr, ad, wd, idle);
    do_search(8'hF0, 8'h0F, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b1, 4'd1, 5'd2}) begin errors++; $display("FAIL ternary_search: got hit=%0b addr=%0d cnt=%0d required 1 1 2", h, a, c); end
  endtask

  task automatic test_contention;
    logic [5:0] order;
    logic [3:0] r_addr [3];
    logic [4:0] r_cnt [3];
    logic       r_hit [3];
    logic       ufire, sfire;
    int g, r, cyc;
    logic [3:0] exp_a;
    logic [4:0] exp_c;
    order = '0; g = 0; r = 0; cyc = 0;
    @(posedge clock); #1;
    upd_address = 4'd5; upd_word = 8'h3C; upd_delete = 1'b0; upd_valid = 1'b1;
    srch_word = 8'h3C; srch_mask = 8'h00; srch_valid = 1'b1;
    while ((g < 6 || r < 3) && cyc < 200) begin
      @(negedge clock); cyc++;
      ufire = upd_valid && upd_ready;
      sfire = srch_valid && srch_ready;
      if (rsp_valid && rsp_ready && r < 3) begin
        r_hit[r] = rsp_hit; r_addr[r] = rsp_address; r_cnt[r] = rsp_count; r++;
      end
      @(posedge clock); #1;
      if (ufire && g < 6) begin order[5 - g] = 1'b1; g++; upd_address = upd_address + 4'd1; end
      if (sfire && g < 6) begin order[5 - g] = 1'b0; g++; end
      if (g >= 6) begin upd_valid = 1'b0; srch_valid = 1'b0; end
    end
    upd_valid = 1'b0; srch_valid = 1'b0;
    checks++;
    if (order !== 6'b101010 || g !== 6) begin errors++; $display("FAIL grant_order: got %b (%0d grants) required 101010 (6 grants)", order, g); end
    checks++;
    if (r !== 3) begin errors++; $display("FAIL contention_responses: got %0d required 3", r); end
    for (int k = 0; k < 3; k++) begin
      if (k < r) begin
        exp_a = 4'd5;
        exp_c = 5'(k + 1);
        checks++;
        if ({r_hit[k], r_addr[k], r_cnt[k]} !== {1'b1, exp_a, exp_c}) begin
          errors++; $display("FAIL contention_rsp%0d: got hit=%0b addr=%0d cnt=%0d required 1 %0d %0d", k, r_hit[k], r_addr[k], r_cnt[k], exp_a, exp_c);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic h; logic [3:0] a; logic [4:0] c; int lat, bad;
    rsp_ready = 1'b0;
    do_search(8'h3C, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b1, 4'd5, 5'd3}) begin errors++; $display("FAIL backpressure_rsp: got hit=%0b addr=%0d cnt=%0d required 1 5 3", h, a, c); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (!(rsp_valid === 1'b1 && rsp_hit === 1'b1 && rsp_address === 4'd5 && rsp_count === 5'd3 &&
            upd_ready === 1'b0 && srch_ready === 1'b0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d unstable cycles required 0", bad); end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, rsp_valid} !== 2'b00 || state !== ST_IDLE) begin
      errors++; $display("FAIL backpressure_release: got busy=%0b rsp_valid=%0b state=%0d required 0 0 %0d", busy, rsp_valid, state, ST_IDLE);
    end
  endtask

  task automatic test_clear;
    logic h; logic [3:0] a; logic [4:0] c; int lat;
    @(posedge clock); #1;
    clr = 1'b1; upd_address = 4'd4; upd_word = 8'h77; upd_delete = 1'b0; upd_valid = 1'b1;
    @(negedge clock);
    checks++;
    if ({upd_ready, srch_ready} !== 2'b00) begin errors++; $display("FAIL clr_priority: got ready=%b required 00", {upd_ready, srch_ready}); end
    @(posedge clock); #1;
    clr = 1'b0; upd_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (state !== ST_CLEAR || {tcam_reset, tcam_write} !== 2'b10) begin
      errors++; $display("FAIL clear_cycle: got state=%0d reset/write=%b required %0d 10", state, {tcam_reset, tcam_write}, ST_CLEAR);
    end
    do_search(8'h3C, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b0, 4'd0, 5'd0}) begin errors++; $display("FAIL search_after_clear: got hit=%0b addr=%0d cnt=%0d required 0 0 0", h, a, c); end
    do_search(8'h00, 8'hFF, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b0, 4'd0, 5'd0}) begin errors++; $display("FAIL wildcard_after_clear: got hit=%0b addr=%0d cnt=%0d required 0 0 0", h, a, c); end
  endtask

  task automatic test_reset_mid_search;
    logic wr, idle; logic [3:0] ad; logic [7:0] wd;
    logic h; logic [3:0] a; logic [4:0] c; int lat, pulses, seen_rsp;
    do_update(4'd4, 8'h11, 1'b0, wr, ad, wd, idle);
    @(posedge clock); #1;
    srch_word = 8'h11; srch_mask = 8'h00; srch_valid = 1'b1;
    @(negedge clock);
    checks++;
    if (srch_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_accept: got %0b required 1", srch_ready); end
    @(posedge clock); #1;
    srch_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (state !== ST_SEARCH) begin errors++; $display("FAIL mid_reset_in_search: got %0d required %0d", state, ST_SEARCH); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    pulses = 0; seen_rsp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (tcam_reset) pulses++;
      if (rsp_valid) seen_rsp++;
    end
    checks++;
    if (seen_rsp !== 0) begin errors++; $display("FAIL mid_reset_rsp_dropped: got %0d rsp cycles required 0", seen_rsp); end
    checks++;
    if (pulses !== 1 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_init: got pulses=%0d busy=%0b required 1 0", pulses, busy); end
    do_search(8'h11, 8'h00, h, a, c, lat);
    checks++;
    if ({h, a, c} !== {1'b0, 4'd0, 5'd0}) begin errors++; $display("FAIL search_after_mid_reset: got hit=%0b addr=%0d cnt=%0d required 0 0 0", h, a, c); end
  endtask

  initial begin
    test_reset;
    test_empty_search;
    test_insert_delete;
    test_ternary;
    test_contention;
    test_backpressure;
    test_clear;
    test_reset_mid_search;
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
